// File: rtl/challenge_pkg.sv
// ----------------------------------------------------------------------------
// challenge_pkg
// Shared definitions for the error-checking challenge protocol. Both the
// checker and the OBC-side responder import this package so that the state
// encoding and the answer function have exactly one definition.
//   QA_W             : question / answer width (4)
//   state_e          : responder state encoding (2 bits)
//   challenge_answer : protocol answer for a given question
// ----------------------------------------------------------------------------
package challenge_pkg;

  localparam int QA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_PRESENT = 2'b10,
    ST_HALT    = 2'b11
  } state_e;

  // Bit 0 is inverted so the all-zero question never yields an all-zero
  // answer; the upper bits are adjacent-pair parities of the question.
  function automatic logic [QA_W-1:0] challenge_answer(input logic [QA_W-1:0] q);
    logic [QA_W-1:0] a;
    a[0] = ~q[0];
    a[1] = q[0] ^ q[1];
    a[2] = q[1] ^ q[2];
    a[3] = q[2] ^ q[3];
    return a;
  endfunction

endpackage

// File: rtl/challenge_responder_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones instead of wrapping.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset (count -> 0)
//   inc    in  increment request
//   clr    in  synchronous clear (highest priority after reset)
//   hold   in  freeze the count (beats inc)
//   count  out current count, WIDTH bits
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold && inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/challenge_responder.sv
// ----------------------------------------------------------------------------
// challenge_responder
// OBC-side responder for the challenge protocol. Accepts a 4-bit question on
// a valid/ready handshake, waits RESP_DELAY cycles, then presents the answer
// on a second valid/ready handshake. An override from the checker latches a
// terminal HALT state that only reset leaves.
//
// Parameters:
//   RESP_DELAY  cycles from question capture to answer presentation (1..15)
//   COUNT_W     width of the answered-question counter
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   question     in   question from the checker (4 bits)
//   q_valid      in   question valid
//   q_ready      out  responder can accept a question (state decode)
//   answer       out  registered answer (4 bits)
//   a_valid      out  answer valid (state decode)
//   a_ready      in   checker accepts the answer
//   override     in   checker shutdown command
//   resp_count   out  answers retired, saturating
//   q_dropped    out  sticky: question offered while not ready
//   fault_inject in   only with CHALLENGE_FAULT_INJECT_EN defined; inverts
//                     answer[0] when the answer is registered
// Build option: CHALLENGE_FAULT_INJECT_EN
// ----------------------------------------------------------------------------
module challenge_responder
  import challenge_pkg::*;
#(
  parameter int RESP_DELAY = 2,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [QA_W-1:0]    question,
  input  logic               q_valid,
  output logic               q_ready,
  output logic [QA_W-1:0]    answer,
  output logic               a_valid,
  input  logic               a_ready,
  input  logic               override,
`ifdef CHALLENGE_FAULT_INJECT_EN
  input  logic               fault_inject,
`endif
  output logic [COUNT_W-1:0] resp_count,
  output logic               q_dropped
);

  localparam logic [3:0] DLY_LOAD = 4'(RESP_DELAY - 1);

  state_e          state;
  logic [3:0]      dly_cnt;
  logic [QA_W-1:0] question_p0;
  logic [QA_W-1:0] answer_p1;
  logic            fault_bit;
  logic            retire;
  logic            cnt_hold;

`ifdef CHALLENGE_FAULT_INJECT_EN
  assign fault_bit = fault_inject;
`else
  assign fault_bit = 1'b0;
`endif

  // Handshake outputs depend on the state register only.
  assign q_ready = (state == ST_IDLE);
  assign a_valid = (state == ST_PRESENT);
  assign answer  = answer_p1;

  // Override on the retire edge discards the answer, so it must gate inc.
  assign retire   = (state == ST_PRESENT) && a_ready && !override;
  assign cnt_hold = (state == ST_HALT) || override;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      question_p0 <= '0;
      answer_p1   <= '0;
      q_dropped   <= 1'b0;
    end else if (override) begin
      state     <= ST_HALT;
      answer_p1 <= '0;
    end else begin
      unique case (state)
        // Stage p0: question capture
        ST_IDLE: begin
          if (q_valid) begin
            question_p0 <= question;
            dly_cnt     <= DLY_LOAD;
            state       <= ST_COMPUTE;
          end
        end
        // Stage p1: answer registered when the delay expires
        ST_COMPUTE: begin
          if (q_valid) begin
            q_dropped <= 1'b1;
          end
          if (dly_cnt == 4'd0) begin
            answer_p1 <= challenge_answer(question_p0) ^ {{(QA_W-1){1'b0}}, fault_bit};
            state     <= ST_PRESENT;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        ST_PRESENT: begin
          // A question offered on the retire cycle is still a drop.
          if (q_valid) begin
            q_dropped <= 1'b1;
          end
          if (a_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_resp_count (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .clr   (1'b0),
    .hold  (cnt_hold),
    .count (resp_count)
  );

endmodule

// File: tb/tb_challenge_responder.sv
module tb_challenge_responder;

  logic       clk;
  logic       reset;
  logic [3:0] question;
  logic       q_valid;
  logic       q_ready;
  logic [3:0] answer;
  logic       a_valid;
  logic       a_ready;
  logic       override;
  logic       fault_inject;
  logic [7:0] resp_count;
  logic       q_dropped;

  int n_cmp;
  int n_err;
  logic [3:0] exp_q[$];

  challenge_responder #(
    .RESP_DELAY (2),
    .COUNT_W    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .question     (question),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .answer       (answer),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .override     (override),
`ifdef CHALLENGE_FAULT_INJECT_EN
    .fault_inject (fault_inject),
`endif
    .resp_count   (resp_count),
    .q_dropped    (q_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted answer is compared with the oldest
  // expected answer queued by the stimulus side.
  always @(negedge clk) begin
    if (a_valid && a_ready && !override) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_answer: got %0h with no expected entry at %0t", answer, $time);
      end else begin
        check("answer", {28'd0, answer}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    q_valid  = 1'b0;
    override = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Waits for q_ready, then offers one question for exactly one edge.
  task automatic send_q(input logic [3:0] q, input bit push, input logic [3:0] exp);
    int t;
    t = 0;
    @(negedge clk);
    while (!q_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!q_ready) begin
      check("q_ready_timeout", 32'(q_ready), 32'd1);
    end else begin
      question = q;
      q_valid  = 1'b1;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      q_valid = 1'b0;
    end
  endtask

  task automatic wait_a_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!a_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("a_valid_wait", 32'(a_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    @(negedge clk);
    while (!(q_ready && exp_q.size() == 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_ready", 32'(q_ready), 32'd1);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b0;
    question     = 4'd0;
    q_valid      = 1'b0;
    a_ready      = 1'b1;
    override     = 1'b0;
    fault_inject = 1'b0;
    #23;
    // reset state
    check("rst_q_ready", 32'(q_ready), 32'd1);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_answer", 32'(answer), 32'd0);
    check("rst_count", 32'(resp_count), 32'd0);
    check("rst_dropped", 32'(q_dropped), 32'd0);
    reset = 1'b1;

    // latency of a single question, a_ready held high
    send_q(4'b0000, 1'b1, 4'b0001);
    @(negedge clk);
    check("lat_n0_a_valid", 32'(a_valid), 32'd0);
    check("lat_n0_q_ready", 32'(q_ready), 32'd0);
    @(negedge clk);
    check("lat_n1_a_valid", 32'(a_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_a_valid", 32'(a_valid), 32'd1);
    check("lat_n2_answer", 32'(answer), 32'h1);
    @(negedge clk);
    check("lat_n3_q_ready", 32'(q_ready), 32'd1);
    check("lat_n3_count", 32'(resp_count), 32'd1);

    // back-to-back questions at the maximum rate
    do_reset();
    send_q(4'b1010, 1'b1, 4'b1111);
    send_q(4'b1111, 1'b1, 4'b0000);
    send_q(4'b0101, 1'b1, 4'b1110);
    wait_drain();
    check("b2b_count", 32'(resp_count), 32'd3);
    check("b2b_dropped", 32'(q_dropped), 32'd0);

    // checker stalls 20 cycles in PRESENT, with a stray question mid-stall
    do_reset();
    a_ready = 1'b0;
    send_q(4'b1010, 1'b1, 4'b1111);
    wait_a_valid();
    for (int i = 0; i < 20; i++) begin
      if (i == 8) begin
        question = 4'b0000;
        q_valid  = 1'b1;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
      check("stall_a_valid", 32'(a_valid), 32'd1);
      check("stall_answer", 32'(answer), 32'hF);
    end
    check("stall_dropped", 32'(q_dropped), 32'd1);
    @(posedge clk);
    #1;
    a_ready = 1'b1;
    wait_drain();
    check("stall_count", 32'(resp_count), 32'd1);

    // override while computing
    do_reset();
    send_q(4'b0101, 1'b0, 4'b0000);
    override = 1'b1;
    @(posedge clk);
    #1;
    override = 1'b0;
    @(negedge clk);
    check("ovc_q_ready", 32'(q_ready), 32'd0);
    check("ovc_a_valid", 32'(a_valid), 32'd0);
    check("ovc_answer", 32'(answer), 32'd0);
    question = 4'b0011;
    q_valid  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    q_valid = 1'b0;
    @(negedge clk);
    check("ovc_halt_q_ready", 32'(q_ready), 32'd0);
    check("ovc_halt_a_valid", 32'(a_valid), 32'd0);
    check("ovc_count", 32'(resp_count), 32'd0);
    check("ovc_dropped", 32'(q_dropped), 32'd0);

    // override while presenting, same edge as an acceptance
    do_reset();
    a_ready = 1'b0;
    send_q(4'b1111, 1'b0, 4'b0000);
    wait_a_valid();
    @(posedge clk);
    #1;
    override = 1'b1;
    a_ready  = 1'b1;
    @(posedge clk);
    #1;
    override = 1'b0;
    @(negedge clk);
    check("ovp_a_valid", 32'(a_valid), 32'd0);
    check("ovp_answer", 32'(answer), 32'd0);
    check("ovp_q_ready", 32'(q_ready), 32'd0);
    check("ovp_count", 32'(resp_count), 32'd0);
    repeat (4) @(negedge clk);
    check("ovp_halt_q_ready", 32'(q_ready), 32'd0);
    check("ovp_halt_count", 32'(resp_count), 32'd0);

    // asynchronous reset in the middle of COMPUTE
    do_reset();
    a_ready = 1'b1;
    send_q(4'b1010, 1'b0, 4'b0000);
    #2;
    reset = 1'b0;
    #1;
    check("arst_q_ready", 32'(q_ready), 32'd1);
    check("arst_a_valid", 32'(a_valid), 32'd0);
    check("arst_answer", 32'(answer), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("arst_no_spurious", 32'(a_valid), 32'd0);
    end
    send_q(4'b0000, 1'b1, 4'b0001);
    wait_drain();
    check("arst_count", 32'(resp_count), 32'd1);

    // counter saturation: 256 retires leave the counter at all-ones
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_q(4'b0011, 1'b1, 4'b0100);
    end
    wait_drain();
    check("sat_count", 32'(resp_count), 32'hFF);

`ifdef CHALLENGE_FAULT_INJECT_EN
    do_reset();
    fault_inject = 1'b1;
    send_q(4'b0000, 1'b1, 4'b0000);
    wait_drain();
    fault_inject = 1'b0;
    send_q(4'b0000, 1'b1, 4'b0001);
    wait_drain();
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
